// File: rtl/stream_arbiter.sv
// Per-slave round-robin arbiter: registers a one-hot grant over the masters' requests.
// Optional macro ARB_PACKET_LOCK_EN holds the grant until the owner's tlast beat is accepted.
module stream_arbiter #(
  parameter int S_DATA_COUNT = 2,
  parameter int IDX_WIDTH    = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [S_DATA_COUNT-1:0] req_i,
  input  logic [S_DATA_COUNT-1:0] s_valid_i,
  input  logic [S_DATA_COUNT-1:0] s_last_i,
  input  logic                    m_ready_i,
  output logic [S_DATA_COUNT-1:0] grant_o,
  output logic [IDX_WIDTH-1:0]    grant_idx_o,
  output logic                    grant_valid_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IDX_WIDTH-1:0]    g_q, g_d;
  logic [IDX_WIDTH-1:0]    ptr_q, ptr_d;
  logic [S_DATA_COUNT-1:0] grant_q, grant_d;

  logic                    sel_found;
  logic [IDX_WIDTH-1:0]    sel_idx;
  int                      cand;
  logic                    beat_acc;
  logic                    release_now;

  // Search starts just after the last granted master and wraps back to it.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      cand = int'(ptr_q) + 1 + i;
      if (cand >= S_DATA_COUNT) cand = cand - S_DATA_COUNT;
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_WIDTH'(cand);
      end
    end
  end

  // grant_q is one-hot on the owner, so masking isolates the owner's valid/last.
  assign beat_acc = (state_q == BUSY) && (|(s_valid_i & grant_q)) && m_ready_i;

`ifdef ARB_PACKET_LOCK_EN
  assign release_now = beat_acc && (|(s_last_i & grant_q));
`else
  logic unused_last;
  assign unused_last = ^s_last_i;
  assign release_now = beat_acc;
`endif

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d = BUSY;
          g_d     = sel_idx;
          ptr_d   = sel_idx;
          grant_d = S_DATA_COUNT'(1) << sel_idx;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d = IDLE;
          g_d     = '0;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = '0;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= IDX_WIDTH'(S_DATA_COUNT - 1);
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = g_q;
  assign grant_valid_o = (state_q == BUSY);

endmodule

// File: tb/tb_stream_arbiter.sv
// Scoreboard bench for stream_arbiter: stimulus pushes predicted outputs, a monitor pops and compares.
// Follows ARB_PACKET_LOCK_EN the same way the design does.
module tb_stream_arbiter;
  localparam int N  = 3;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_i = '0;
  logic [N-1:0]  s_valid_i = '0;
  logic [N-1:0]  s_last_i = '0;
  logic          m_ready_i = 1'b0;
  logic [N-1:0]  grant_o;
  logic [IW-1:0] grant_idx_o;
  logic          grant_valid_o;

  stream_arbiter #(.S_DATA_COUNT(N), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .s_valid_i(s_valid_i),
    .s_last_i(s_last_i), .m_ready_i(m_ready_i), .grant_o(grant_o),
    .grant_idx_o(grant_idx_o), .grant_valid_o(grant_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] grant;
    int           idx;
    logic         valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   started = 0;

  // Reference model: owner (-1 = none) and last-granted master.
  int owner = -1;
  int ptr   = N - 1;

`ifdef ARB_PACKET_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  task automatic model_edge(input bit rst, input logic [N-1:0] req,
                            input logic [N-1:0] vld, input logic [N-1:0] lst,
                            input logic rdy);
    exp_t e;
    if (!rst) begin
      owner = -1;
      ptr   = N - 1;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (req[c]) begin
          owner = c;
          ptr   = c;
          break;
        end
      end
    end else begin
      if (vld[owner] && rdy && (!LOCK || lst[owner])) owner = -1;
    end
    e.valid = (owner >= 0);
    e.idx   = (owner >= 0) ? owner : 0;
    e.grant = (owner >= 0) ? N'(1 << owner) : '0;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs on the falling edge and predict the state after the next rising edge.
  task automatic step(input bit rst, input logic [N-1:0] req, input logic [N-1:0] vld,
                      input logic [N-1:0] lst, input logic rdy);
    @(negedge clk);
    req_i = req; s_valid_i = vld; s_last_i = lst; m_ready_i = rdy;
    if (!rst && rst_n) begin
      rst_n = 1'b0;
      #1;
      checks++;
      if (grant_o !== '0 || grant_valid_o !== 1'b0 || grant_idx_o !== '0) begin
        fails++;
        $display("FAIL async_reset: grant=%b valid=%b idx=%0d, required all zero",
                 grant_o, grant_valid_o, grant_idx_o);
      end
    end
    rst_n = rst;
    model_edge(rst, req, vld, lst, rdy);
    started = 1;
  endtask

  initial begin : monitor
    exp_t e;
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: no expected entry at time %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (grant_o !== e.grant) begin
          fails++;
          $display("FAIL grant @%0t: got %b required %b", $time, grant_o, e.grant);
        end
        checks++;
        if (grant_valid_o !== e.valid) begin
          fails++;
          $display("FAIL grant_valid @%0t: got %b required %b", $time, grant_valid_o, e.valid);
        end
        if (e.valid) begin
          checks++;
          if (int'(grant_idx_o) != e.idx) begin
            fails++;
            $display("FAIL grant_idx @%0t: got %0d required %0d", $time, grant_idx_o, e.idx);
          end
        end
      end
    end
  end

  initial begin : stimulus
    // Reset, then full contention with every beat a last beat: 001,000,010,000,100,000,001.
    step(0, '0, '0, '0, 0);
    step(0, '0, '0, '0, 0);
    for (int i = 0; i < 8; i++) step(1, 3'b111, 3'b111, 3'b111, 1);

    // Owner 0 packet with a contender: valid gaps, ready stalls on last, then release.
    step(0, '0, '0, '0, 0);
    step(1, 3'b011, 3'b000, 3'b000, 0);
    step(1, 3'b010, 3'b011, 3'b000, 1);
    step(1, 3'b010, 3'b010, 3'b010, 1);
    step(1, 3'b010, 3'b010, 3'b010, 1);
    step(1, 3'b010, 3'b011, 3'b000, 1);
    for (int i = 0; i < 4; i++) step(1, 3'b010, 3'b011, 3'b011, 0);
    step(1, 3'b010, 3'b011, 3'b011, 1);
    step(1, 3'b010, 3'b000, 3'b000, 0);
    step(1, 3'b010, 3'b000, 3'b000, 0);

    // Reset while master 1 owns the slave, then restart from master 0 priority.
    step(0, '0, '0, '0, 0);
    step(1, 3'b010, 3'b000, 3'b000, 0);
    step(1, 3'b010, 3'b000, 3'b000, 0);
    step(0, 3'b011, 3'b000, 3'b000, 0);
    step(1, 3'b011, 3'b000, 3'b000, 0);
    step(1, 3'b011, 3'b000, 3'b000, 0);

    // Randomized traffic with rare resets.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      r = ($urandom_range(0, 299) != 0);
      step(r, N'($urandom), N'($urandom | $urandom),
           N'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
# stream_arbiter

Per-slave round-robin arbiter for the stream crossbar. One instance sits directly downstream of each slave port's request generator. It consumes that generator's per-master request vector and registers a one-hot grant, which drives the data/valid mux toward the slave and the ready demux back to the masters. With packet locking compiled in, a grant is held from the first accepted beat until the granted master's last beat is accepted.

## Interface
- S_DATA_COUNT, default 2: number of masters competing for this slave; minimum 1.
- IDX_WIDTH, default $clog2(S_DATA_COUNT) forced to at least 1: width of the grant index.
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_i  input  S_DATA_COUNT  per-master request toward this slave, from the request generator.
- s_valid_i  input  S_DATA_COUNT  per-master tvalid.
- s_last_i  input  S_DATA_COUNT  per-master tlast.
- m_ready_i  input  1  tready from this slave.
- grant_o  output  S_DATA_COUNT  registered one-hot grant; all-zero means no owner.
- grant_idx_o  output  IDX_WIDTH  binary index of the granted master; valid only while grant_valid_o is 1.
- grant_valid_o  output  1  registered; equals |grant_o.

## Operation
- States: IDLE (no owner) and BUSY (owner g held in a register).
- Round-robin pointer ptr holds the last granted master.
  - Search order: ptr+1, ptr+2, … wrapping modulo S_DATA_COUNT, ending at ptr itself.
- IDLE:
  - If req_i is nonzero, grant the first set bit in search order, load g and ptr with it, and go to BUSY.
  - If req_i is zero, stay in IDLE; outputs stay zero.
- Beat accepted: s_valid_i[g] and m_ready_i both high while in BUSY.
- BUSY release condition:
  - With the lock macro defined: a beat is accepted and s_last_i[g] is high.
  - Without the lock macro: any accepted beat.
- On release, clear the grant and return to IDLE. There is no same-edge regrant; one bubble cycle always follows a release.
- In BUSY, req_i is ignored.
  - The owner keeps the grant even if its req_i or s_valid_i drops mid-packet.
  - Requests from other masters do not preempt the owner.
- Masters other than g never influence release, regardless of their valid or last inputs.
- S_DATA_COUNT = 1: ptr is a constant 0; the FSM still runs with the same timing.

## Timing
- Reset values:
  - State = IDLE.
  - grant_o = 0, grant_idx_o = 0, grant_valid_o = 0.
  - ptr = S_DATA_COUNT-1, so master 0 has first priority after reset.
- Grant latency: req_i sampled high in IDLE at edge N gives grant_o valid immediately after edge N. The combinational request-to-grant path ends in a register.
- Release: the final accepted beat at edge E clears grant_o after E.
  - The earliest next grant appears after edge E+1, i.e. one idle cycle.
- Outputs change only on clock edges. There is no combinational path from any input to any output.
- Reset asserted mid-packet immediately clears grant and state and restores ptr.
  - A packet in flight is abandoned; its remainder must re-request.

## Configuration
- ARB_PACKET_LOCK_EN
  - Defined: the grant is held for a whole packet and released only on an accepted beat with tlast.
  - Not defined: the grant is released after every accepted beat, giving beat-level round-robin interleaving; s_last_i is unused.

## Test plan
- Reset, then req_i=2'b11 -> grant_o=2'b01 one cycle later and grant_idx_o=0. After the release and one bubble cycle, with req still 2'b11 -> grant_o=2'b10.
- Lock on, owner 0 sends a 3-beat packet with m_ready_i=1, while req_i[1]=1 throughout -> grant_o stays 2'b01 for all 3 beats, goes 0 for 1 cycle, then becomes 2'b10.
- Lock on, m_ready_i=0 while s_last_i[0]=1 for 4 cycles -> grant held. When m_ready_i rises -> release on that edge.
- Lock on, owner drops s_valid_i mid-packet for 2 cycles while master 1 requests -> grant stays 2'b01, no preemption.
- Lock off, S_DATA_COUNT=3, req_i=3'b111, m_ready_i=1, all valid -> grants cycle 001, 000, 010, 000, 100, 000, 001.
- Assert rst_n low during BUSY with owner 1 -> all outputs 0 immediately. After rst_n rises with req_i=2'b11 -> grant_o=2'b01.
